align_mant_shift: RTL and testbench

- Alignment stage directly downstream of the exponent-select stage.
- Takes both 24-bit mantissas (hidden bit included), the larger exponent, the exponent difference and the swap flag.
- Swaps the operands, then right-shifts the smaller-exponent mantissa by the difference, one log2 stage per cycle, into a 27-bit field with guard/round/sticky bits.
- Valid/ready handshake on both sides; results feed the mantissa add/sub stage.

---
 rtl/fpu_align_pkg.sv | 15 +
 rtl/align_mant_shift_if.sv | 39 +++
 rtl/align_mant_shift_step.sv | 18 +
 rtl/align_mant_shift.sv | 136 +++++++++++++
 tb/tb_align_mant_shift.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/fpu_align_pkg.sv
// Shared widths, shift constants and FSM state type for the mantissa
// alignment stage.
package fpu_align_pkg;
  localparam int MANT_W       = 24;
  localparam int GRS_W        = 3;
  localparam int ALN_W        = MANT_W + GRS_W;
  localparam int SHIFT_STAGES = 5;
  localparam logic [4:0] SAT_SHIFT = 5'd31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/align_mant_shift_if.sv
// Operand/result bundle of the alignment stage. Both sides use valid/ready:
// a transfer happens on a rising edge where valid & ready are both high, and
// the sender holds its data and valid stable until that edge.
interface align_mant_shift_if;
  import fpu_align_pkg::*;

  logic              i_valid;
  logic              o_ready;
  logic [MANT_W-1:0] i_MantA;
  logic [MANT_W-1:0] i_MantB;
  logic              i_SignA;
  logic              i_SignB;
  logic [7:0]        i_Exp;
  logic [7:0]        i_E_sub;
  logic              i_Ce_lt;

  logic              o_valid;
  logic              i_ready;
  logic [ALN_W-1:0]  o_MantBig;
  logic [ALN_W-1:0]  o_MantSml;
  logic              o_SignBig;
  logic              o_SignSml;
  logic [7:0]        o_Exp;
  logic              o_swap;

  modport slave (
    input  i_valid, i_MantA, i_MantB, i_SignA, i_SignB, i_Exp, i_E_sub,
           i_Ce_lt, i_ready,
    output o_ready, o_valid, o_MantBig, o_MantSml, o_SignBig, o_SignSml,
           o_Exp, o_swap
  );

  modport master (
    output i_valid, i_MantA, i_MantB, i_SignA, i_SignB, i_Exp, i_E_sub,
           i_Ce_lt, i_ready,
    input  o_ready, o_valid, o_MantBig, o_MantSml, o_SignBig, o_SignSml,
           o_Exp, o_swap
  );
endinterface

// File: rtl/align_mant_shift_step.sv
// One log2 stage of the sticky right shifter: shifts by weight when enabled
// and ORs every bit pushed off the bottom (old bit 0 included) into bit 0.
module align_shift_step
  import fpu_align_pkg::*;
(
  input  logic [ALN_W-1:0] data,
  input  logic             enable,
  input  logic [4:0]       weight,
  output logic [ALN_W-1:0] result
);
  logic [ALN_W-1:0] shifted;
  logic [ALN_W-1:0] lost_mask;

  assign shifted   = data >> weight;
  assign lost_mask = ~({ALN_W{1'b1}} << weight);
  assign result    = enable ? {shifted[ALN_W-1:1], shifted[0] | (|(data & lost_mask))}
                            : data;
endmodule

// File: rtl/align_mant_shift.sv
// Operand swap and sticky right-alignment of the smaller mantissa.
// Define ALIGN_FAST_EN for a single-cycle barrel shifter instead of the
// default one-stage-per-cycle iterative shifter; results are identical.
module align_mant_shift
  import fpu_align_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  align_mant_shift_if.slave  bus,
  output state_e             dbg_state
);
  state_e           state, state_n;
  logic [ALN_W-1:0] big_q, big_n, sml_q, sml_n;
  logic             sign_big_q, sign_big_n, sign_sml_q, sign_sml_n;
  logic [7:0]       exp_q, exp_n;
  logic             swap_q, swap_n;
  logic             accept;
  logic [4:0]       in_amt;
  logic [ALN_W-1:0] in_big, in_sml;

  assign bus.o_ready = ~i_rst & ((state == IDLE) | ((state == DONE) & bus.i_ready));
  assign accept      = bus.i_valid & bus.o_ready;
  assign in_amt      = (|bus.i_E_sub[7:5]) ? SAT_SHIFT : bus.i_E_sub[4:0];
  assign in_big      = bus.i_Ce_lt ? {bus.i_MantB, {GRS_W{1'b0}}} : {bus.i_MantA, {GRS_W{1'b0}}};
  assign in_sml      = bus.i_Ce_lt ? {bus.i_MantA, {GRS_W{1'b0}}} : {bus.i_MantB, {GRS_W{1'b0}}};

`ifdef ALIGN_FAST_EN
  logic [ALN_W-1:0] chain [0:SHIFT_STAGES];

  assign chain[0] = in_sml;
  for (genvar g = 0; g < SHIFT_STAGES; g++) begin : g_stage
    align_shift_step u_stage (
      .data   (chain[g]),
      .enable (in_amt[SHIFT_STAGES-1-g]),
      .weight (5'(16 >> g)),
      .result (chain[g+1])
    );
  end
`else
  logic [2:0]       step, step_n;
  logic [4:0]       amt_q, amt_n;
  logic [4:0]       weight;
  logic [ALN_W-1:0] step_out;

  // Step k handles amount bit (4-k); weight is that bit's one-hot value.
  assign weight = 5'd16 >> step;

  align_shift_step u_step (
    .data   (sml_q),
    .enable (|(amt_q & weight)),
    .weight (weight),
    .result (step_out)
  );
`endif

  always_comb begin
    state_n    = state;
    big_n      = big_q;
    sml_n      = sml_q;
    sign_big_n = sign_big_q;
    sign_sml_n = sign_sml_q;
    exp_n      = exp_q;
    swap_n     = swap_q;
`ifndef ALIGN_FAST_EN
    step_n     = step;
    amt_n      = amt_q;
`endif
    unique case (state)
      IDLE: state_n = IDLE;
`ifndef ALIGN_FAST_EN
      SHIFT: begin
        sml_n  = step_out;
        step_n = step + 3'd1;
        if (step == 3'd4) state_n = DONE;
      end
`endif
      DONE: if (bus.i_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // accept is only possible from IDLE or a draining DONE, so it overrides.
    if (accept) begin
      big_n      = in_big;
      sign_big_n = bus.i_Ce_lt ? bus.i_SignB : bus.i_SignA;
      sign_sml_n = bus.i_Ce_lt ? bus.i_SignA : bus.i_SignB;
      exp_n      = bus.i_Exp;
      swap_n     = bus.i_Ce_lt;
`ifdef ALIGN_FAST_EN
      sml_n      = chain[SHIFT_STAGES];
      state_n    = DONE;
`else
      sml_n      = in_sml;
      amt_n      = in_amt;
      step_n     = 3'd0;
      state_n    = SHIFT;
`endif
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      big_q      <= '0;
      sml_q      <= '0;
      sign_big_q <= 1'b0;
      sign_sml_q <= 1'b0;
      exp_q      <= '0;
      swap_q     <= 1'b0;
`ifndef ALIGN_FAST_EN
      step       <= 3'd0;
      amt_q      <= 5'd0;
`endif
    end else begin
      state      <= state_n;
      big_q      <= big_n;
      sml_q      <= sml_n;
      sign_big_q <= sign_big_n;
      sign_sml_q <= sign_sml_n;
      exp_q      <= exp_n;
      swap_q     <= swap_n;
`ifndef ALIGN_FAST_EN
      step       <= step_n;
      amt_q      <= amt_n;
`endif
    end
  end

  assign bus.o_valid   = (state == DONE);
  assign bus.o_MantBig = big_q;
  assign bus.o_MantSml = sml_q;
  assign bus.o_SignBig = sign_big_q;
  assign bus.o_SignSml = sign_sml_q;
  assign bus.o_Exp     = exp_q;
  assign bus.o_swap    = swap_q;
  assign dbg_state     = state;
endmodule

// File: tb/tb_align_mant_shift.sv
// Self-checking bench for align_mant_shift: directed vector table, handshake
// and reset corner sequences, and random transactions against a reference model.
module tb_align_mant_shift;
  import fpu_align_pkg::*;

`ifdef ALIGN_FAST_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 6;
`endif

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic        sa;
    logic        sb;
    logic [7:0]  exp;
    logic [7:0]  esub;
    logic        ce;
    logic [26:0] big;
    logic [26:0] sml;
  } vec_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_e dbg_state;
  int     tests = 0;
  int     fails = 0;

  align_mant_shift_if bus ();

  align_mant_shift dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Reference: sticky right shift of {mant,000} by min(e_sub,31) in plain arithmetic.
  function automatic logic [26:0] model_sml(input logic [23:0] m, input logic [7:0] e);
    longint unsigned v, n, r;
    v = longint'(m) * 8;
    n = (e > 8'd31) ? 31 : longint'(e);
    r = v >> n;
    if ((v % (64'd1 << n)) != 0) r = r | 64'd1;
    return r[26:0];
  endfunction

  function automatic vec_t make_vec(input logic [23:0] a, input logic [23:0] b,
                                    input logic sa, input logic sb, input logic [7:0] exp,
                                    input logic [7:0] esub, input logic ce);
    vec_t v;
    v.a = a; v.b = b; v.sa = sa; v.sb = sb; v.exp = exp; v.esub = esub; v.ce = ce;
    v.big = 27'(longint'(ce ? b : a) * 8);
    v.sml = model_sml(ce ? a : b, esub);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.i_MantA = v.a;
    bus.i_MantB = v.b;
    bus.i_SignA = v.sa;
    bus.i_SignB = v.sb;
    bus.i_Exp   = v.exp;
    bus.i_E_sub = v.esub;
    bus.i_Ce_lt = v.ce;
  endtask

  task automatic chk_out(input vec_t v, input string tag);
    chk({tag, "_valid"}, 32'(bus.o_valid), 32'd1);
    chk({tag, "_big"}, 32'(bus.o_MantBig), 32'(v.big));
    chk({tag, "_sml"}, 32'(bus.o_MantSml), 32'(v.sml));
    chk({tag, "_sbig"}, 32'(bus.o_SignBig), 32'(v.ce ? v.sb : v.sa));
    chk({tag, "_ssml"}, 32'(bus.o_SignSml), 32'(v.ce ? v.sa : v.sb));
    chk({tag, "_exp"}, 32'(bus.o_Exp), 32'(v.exp));
    chk({tag, "_swap"}, 32'(bus.o_swap), 32'(v.ce));
  endtask

  // Called #1 after the accept edge; counts edges (accept edge = 1) until o_valid.
  task automatic wait_valid(input string tag);
    int cnt;
    cnt = 1;
    while (!bus.o_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk({tag, "_lat"}, 32'(cnt), 32'(LAT));
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int cnt;
    @(negedge clk);
    drive(v);
    bus.i_valid = 1'b1;
    bus.i_ready = 1'b0;
    cnt = 0;
    while (!bus.o_ready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, "_rdy"}, 32'(bus.o_ready), 32'd1);
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    wait_valid(tag);
    chk_out(v, tag);
    @(negedge clk);
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_ready = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(bus.o_valid), 32'd0);
    chk({tag, "_rdy"}, 32'(bus.o_ready), 32'd0);
    chk({tag, "_big"}, 32'(bus.o_MantBig), 32'd0);
    chk({tag, "_sml"}, 32'(bus.o_MantSml), 32'd0);
    chk({tag, "_sbig"}, 32'(bus.o_SignBig), 32'd0);
    chk({tag, "_ssml"}, 32'(bus.o_SignSml), 32'd0);
    chk({tag, "_exp"}, 32'(bus.o_Exp), 32'd0);
    chk({tag, "_swap"}, 32'(bus.o_swap), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  vec_t vecs [8];

  initial begin
    vec_t v1, v2;
    // Expected values here are hand-derived constants.
    vecs[0] = '{24'hC00000, 24'h800000, 1'b0, 1'b1, 8'h80, 8'd1,   1'b0, 27'h6000000, 27'h2000000};
    vecs[1] = '{24'h800001, 24'hFFFFFF, 1'b1, 1'b0, 8'h90, 8'd3,   1'b1, 27'h7FFFFF8, 27'h0800001};
    vecs[2] = '{24'h123456, 24'hABCDEF, 1'b0, 1'b0, 8'h70, 8'd200, 1'b0, 27'h091A2B0, 27'h0000001};
    vecs[3] = '{24'h800000, 24'h000000, 1'b1, 1'b1, 8'h71, 8'd200, 1'b0, 27'h4000000, 27'h0000000};
    vecs[4] = '{24'hFFFFFF, 24'hABCDEF, 1'b0, 1'b1, 8'h20, 8'd0,   1'b0, 27'h7FFFFF8, 27'h55E6F78};
    vecs[5] = '{24'h800000, 24'h900000, 1'b1, 1'b0, 8'h21, 8'd27,  1'b1, 27'h4800000, 27'h0000001};
    vecs[6] = '{24'hC00000, 24'h800000, 1'b0, 1'b1, 8'h22, 8'd25,  1'b1, 27'h4000000, 27'h0000003};
    vecs[7] = '{24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b1, 8'hFE, 8'd32,  1'b0, 27'h7FFFFF8, 27'h0000001};

    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    drive(vecs[0]);

    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post_reset_rdy", 32'(bus.o_ready), 32'd1);
    chk("post_reset_valid", 32'(bus.o_valid), 32'd0);

    for (int i = 0; i < 8; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: hold DONE for 4 cycles, then accept a new operand on release.
    v1 = make_vec(24'hA5A5A5, 24'h8F0F0F, 1'b0, 1'b1, 8'h55, 8'd5, 1'b1);
    v2 = make_vec(24'hF00001, 24'h812345, 1'b1, 1'b0, 8'h66, 8'd9, 1'b0);
    @(negedge clk);
    drive(v1);
    bus.i_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    wait_valid("bp1");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_out(v1, "bp_hold");
      chk("bp_hold_rdy", 32'(bus.o_ready), 32'd0);
    end
    @(negedge clk);
    drive(v2);
    bus.i_valid = 1'b1;
    bus.i_ready = 1'b1;
    #1 chk("bp_b2b_rdy", 32'(bus.o_ready), 32'd1);
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    wait_valid("bp2");
    chk_out(v2, "bp2");
    @(negedge clk);
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_ready = 1'b0;

    // Asynchronous reset during the third shift cycle.
    @(negedge clk);
    drive(v1);
    bus.i_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_zero("mid_rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("mid_rst_rel_rdy", 32'(bus.o_ready), 32'd1);
    run_txn(v2, "after_rst");

    // Random transactions against the reference model.
    for (int i = 0; i < 100; i++) begin
      logic [23:0] a, b;
      logic [7:0]  e;
      a = ($urandom_range(0, 15) == 0) ? 24'h0 : (24'h800000 | 24'($urandom));
      b = ($urandom_range(0, 15) == 0) ? 24'h0 : (24'h800000 | 24'($urandom));
      e = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 30));
      run_txn(make_vec(a, b, 1'($urandom), 1'($urandom), 8'($urandom), e, 1'($urandom)),
              $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
